// File: rtl/axis_pipeliner_credit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axis_pipeliner_credit_pkg
// Brief   : shared sizing helper and parameter legality checks for AXIS blocks
// Revision: 1.0
// ============================================================================
package axis_pipeliner_credit_pkg;

  // Constant-foldable ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 1) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int stages, input int qual_width, input int depth);
    return (stages >= 1) && (qual_width >= 1) && is_pow2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_pipeliner_fifo.sv
`default_nettype none
// ============================================================================
// Module  : axis_pipeliner_fifo
// Brief   : synchronous first-word-fall-through FIFO with level and sticky overflow
// Revision: 1.0
// ============================================================================
module axis_pipeliner_fifo
  import axis_pipeliner_credit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic [clog2(DEPTH):0]   level,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow
);

  localparam int c_AW = clog2(DEPTH);
  localparam int c_IW = (c_AW == 0) ? 1 : c_AW;
  localparam logic [c_IW-1:0] c_IDX_MASK   = c_IW'(DEPTH - 1);
  localparam logic [c_AW:0]   c_FULL_LEVEL = (c_AW + 1)'(DEPTH);
  localparam logic [c_AW:0]   c_PTR_ONE    = (c_AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             r_overflow;
  logic [c_IW-1:0]  w_wr_idx;
  logic [c_IW-1:0]  w_rd_idx;
  logic             w_do_wr;
  logic             w_do_rd;

  // Extra pointer MSB separates full from empty; the mask collapses DEPTH=1 to slot 0.
  assign w_wr_idx = r_wr_ptr[c_IW-1:0] & c_IDX_MASK;
  assign w_rd_idx = r_rd_ptr[c_IW-1:0] & c_IDX_MASK;

  assign level    = r_wr_ptr - r_rd_ptr;
  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (level == c_FULL_LEVEL);
  assign overflow = r_overflow;
  assign rd_data  = r_mem[w_rd_idx];

  assign w_do_rd = rd_en & ~empty;
  assign w_do_wr = wr_en & (~full | w_do_rd);

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[w_wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      if (wr_en & ~w_do_wr) r_overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_pipeliner_credit.sv
`default_nettype none
// ============================================================================
// Module  : axis_pipeliner_credit
// Brief   : credit-based AXI4-Stream wrapper around a free-running fixed-latency pipeline
// Revision: 1.0
// ============================================================================
module axis_pipeliner_credit
  import axis_pipeliner_credit_pkg::*;
#(
  parameter int PIPE_DATA_IN_WIDTH  = 32,
  parameter int PIPE_DATA_OUT_WIDTH = 32,
  parameter int PIPE_QUAL_WIDTH     = 4,
  parameter int PIPE_STAGES         = 8,
  parameter int FIFO_DEPTH          = 16
) (
  input  logic                            axis_aclk,
  input  logic                            axis_areset,
  input  logic [PIPE_DATA_IN_WIDTH-1:0]   s_axis_tdata,
  input  logic [PIPE_QUAL_WIDTH-1:0]      s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [PIPE_DATA_OUT_WIDTH-1:0]  m_axis_tdata,
  output logic [PIPE_QUAL_WIDTH-1:0]      m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            pipe_cen,
  output logic [PIPE_DATA_IN_WIDTH-1:0]   pipe_in_data,
  input  logic [PIPE_DATA_OUT_WIDTH-1:0]  pipe_out_data,
  output logic [clog2(FIFO_DEPTH):0]      fifo_level,
  output logic [clog2(FIFO_DEPTH):0]      outstanding,
  output logic                            overflow_err
);

  localparam int c_LW = clog2(FIFO_DEPTH) + 1;
  localparam int c_FW = PIPE_DATA_OUT_WIDTH + PIPE_QUAL_WIDTH + 1;
  localparam logic [c_LW-1:0] c_CREDITS = c_LW'(FIFO_DEPTH);

  generate
    if (!params_legal(PIPE_STAGES, PIPE_QUAL_WIDTH, FIFO_DEPTH)) begin : g_param_check
      $error("axis_pipeliner_credit: need PIPE_STAGES>=1, PIPE_QUAL_WIDTH>=1, FIFO_DEPTH power of two");
    end
  endgenerate

  logic                        r_s_axis_tready;
  logic                        r_pipe_cen;
  logic [PIPE_STAGES-1:0]      r_valid_pipe;
  logic [PIPE_STAGES-1:0]      r_last_pipe;
  logic [PIPE_QUAL_WIDTH-1:0]  r_user_pipe [PIPE_STAGES];
  logic [c_LW-1:0]             r_outstanding;
  logic [c_LW-1:0]             w_outstanding_next;
  logic                        w_accept;
  logic                        w_pop;
  logic                        w_fifo_empty;
  logic                        w_fifo_full;
  logic [c_FW-1:0]             w_fifo_wr_data;
  logic [c_FW-1:0]             w_fifo_rd_data;

  assign w_accept           = s_axis_tvalid & r_s_axis_tready;
  assign w_pop              = m_axis_tvalid & m_axis_tready;
  assign w_outstanding_next = r_outstanding + c_LW'(w_accept) - c_LW'(w_pop);

  assign s_axis_tready = r_s_axis_tready;
  assign pipe_cen      = r_pipe_cen;
  assign pipe_in_data  = s_axis_tdata;
  assign outstanding   = r_outstanding;

  // Ready depends only on registered state, so m_axis_tready never reaches the source side combinationally.
  always_ff @(posedge axis_aclk) begin
    r_pipe_cen <= ~axis_areset;
    if (axis_areset) begin
      r_valid_pipe    <= '0;
      r_last_pipe     <= '0;
      r_outstanding   <= '0;
      r_s_axis_tready <= 1'b0;
      for (int i = 0; i < PIPE_STAGES; i++) r_user_pipe[i] <= '0;
    end else begin
      r_valid_pipe[0] <= w_accept;
      r_last_pipe[0]  <= s_axis_tlast;
      r_user_pipe[0]  <= s_axis_tuser;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        r_valid_pipe[i] <= r_valid_pipe[i-1];
        r_last_pipe[i]  <= r_last_pipe[i-1];
        r_user_pipe[i]  <= r_user_pipe[i-1];
      end
      r_outstanding   <= w_outstanding_next;
      // The full term is a backstop; with correct credit accounting it never changes the result.
      r_s_axis_tready <= (w_outstanding_next < c_CREDITS) & ~(w_fifo_full & ~w_pop);
    end
  end

  assign w_fifo_wr_data = {pipe_out_data, r_user_pipe[PIPE_STAGES-1], r_last_pipe[PIPE_STAGES-1]};

  axis_pipeliner_fifo #(
    .WIDTH (c_FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (axis_aclk),
    .rst      (axis_areset),
    .wr_en    (r_valid_pipe[PIPE_STAGES-1]),
    .wr_data  (w_fifo_wr_data),
    .rd_en    (m_axis_tready),
    .rd_data  (w_fifo_rd_data),
    .level    (fifo_level),
    .full     (w_fifo_full),
    .empty    (w_fifo_empty),
    .overflow (overflow_err)
  );

  assign m_axis_tvalid = ~w_fifo_empty;
  assign {m_axis_tdata, m_axis_tuser, m_axis_tlast} = w_fifo_rd_data;

endmodule
`default_nettype wire
